// File: rtl/pea_output_drain_pkg.sv
// Shared definitions for the PEA output drain: FSM state encoding,
// beat-index constants and the log2 helper used for pop-count widths.
package pea_output_drain_pkg;

  // Drain FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  // Beat order on the output stream: result word first, high half first
  localparam logic [1:0] BEAT_RES_HI = 2'd0;
  localparam logic [1:0] BEAT_RES_LO = 2'd1;
  localparam logic [1:0] BEAT_STA_HI = 2'd2;
  localparam logic [1:0] BEAT_STA_LO = 2'd3;

  // Ceiling log2, used to size occupancy and counter buses
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pea_output_drain_desync_watchdog.sv
// Pairing watchdog: counts consecutive enabled cycles in which exactly one
// of the two output FIFOs holds data, and raises a sticky flag once that
// run reaches DESYNC_LIMIT. The flag only reports; it never stalls draining.
module pea_output_drain_desync_watchdog
  import pea_output_drain_pkg::*;
#(
  parameter int POP_W        = 5,
  parameter int DESYNC_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  output logic             desync
);

  localparam int CNT_W = log2(DESYNC_LIMIT + 1);

  logic [CNT_W-1:0] run_cnt;
  logic             one_sided;

  assign one_sided = (|result_pop) ^ (|status_pop);

  // Run-length counter saturating at the limit, plus the sticky flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
      desync  <= 1'b0;
    end else if (enable) begin
      if (one_sided) begin
        if (run_cnt != CNT_W'(DESYNC_LIMIT)) run_cnt <= run_cnt + CNT_W'(1);
        if (run_cnt == CNT_W'(DESYNC_LIMIT - 1)) desync <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pea_output_drain.sv
// Host-side reader for the PEA output path. Pops one word from the result
// FIFO and one from the status FIFO together, then streams the pair as four
// width-bit beats (result hi, result lo, status hi, status lo).
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both 1; once out_valid rises, out_data and out_valid hold
// unchanged until that transfer, and out_valid never drops without one
// (except on reset, which drops the pair in progress).
//
// FIFO read timing: the rd_en pulse is high for the whole POP cycle, the
// FIFO advances on the edge ending POP, and its read data is captured in WAIT.
module pea_output_drain
  import pea_output_drain_pkg::*;
#(
  parameter int buffer_size_out = 32,
  parameter int width           = 16,
  parameter int DESYNC_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               drain_en,
  input  logic [log2(buffer_size_out)-1:0]   result_pop,
  input  logic [log2(buffer_size_out)-1:0]   status_pop,
  input  logic [2*width-1:0]                 result_data,
  input  logic [2*width-1:0]                 status_data,
  output logic                               rd_en_result,
  output logic                               rd_en_status,
  output logic [width-1:0]                   out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [15:0]                        pair_count,
  output logic                               desync,
  output logic [1:0]                         dbg_state
);

  localparam int POP_W = log2(buffer_size_out);

  state_t             state;
  logic [4*width-1:0] shift_reg;
  logic [1:0]         beat_idx;
  logic [1:0]         next_idx;
  logic               can_start;
  logic               accept;

  assign can_start = drain_en && (|result_pop) && (|status_pop);
  assign accept    = out_valid && out_ready;
  assign next_idx  = beat_idx + 2'd1;
  assign dbg_state = state;

  // Slice one beat out of the captured pair
  function automatic logic [width-1:0] beat_word(input logic [4*width-1:0] s,
                                                 input logic [1:0] idx);
    logic [width-1:0] w;
    w = '0;
    case (idx)
      BEAT_RES_HI: w = s[4*width-1 -: width];
      BEAT_RES_LO: w = s[3*width-1 -: width];
      BEAT_STA_HI: w = s[2*width-1 -: width];
      BEAT_STA_LO: w = s[width-1:0];
      default:     w = '0;
    endcase
    return w;
  endfunction

  // Drain FSM with registered strobes, beat output and pair counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rd_en_result <= 1'b0;
      rd_en_status <= 1'b0;
      shift_reg    <= '0;
      beat_idx     <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      pair_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (can_start) begin
            rd_en_result <= 1'b1;
            rd_en_status <= 1'b1;
            state        <= ST_POP;
          end
        end
        ST_POP: begin
          rd_en_result <= 1'b0;
          rd_en_status <= 1'b0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          shift_reg <= {result_data, status_data};
          beat_idx  <= BEAT_RES_HI;
          out_data  <= result_data[2*width-1 -: width];
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (accept) begin
            if (beat_idx == BEAT_STA_LO) begin
              out_valid  <= 1'b0;
              out_data   <= '0;
              pair_count <= pair_count + 16'd1;
              state      <= ST_IDLE;
            end else begin
              beat_idx <= next_idx;
              out_data <= beat_word(shift_reg, next_idx);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pea_output_drain_desync_watchdog #(
    .POP_W        (POP_W),
    .DESYNC_LIMIT (DESYNC_LIMIT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .enable     (state == ST_IDLE),
    .result_pop (result_pop),
    .status_pop (status_pop),
    .desync     (desync)
  );

endmodule
